eth_rx_mac_filter: RTL and testbench

//  Sits between Ethernet MAC RX AXI-Stream (8-bit, gtx_tclk_i domain) and cmd_decoder_top rx_axis input.

---
 rtl/eth_rx_mac_filter.sv | 207 ++++++++++++++++++++
 tb/tb_eth_rx_mac_filter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_mac_filter.sv
// eth_rx_mac_filter
//   Destination-MAC filter between the Ethernet MAC RX AXI-Stream (8-bit) and
//   the command decoder. The first six bytes of each frame are held and
//   compared against FPGA_MAC_ADDR (and broadcast when accept_bcast_i=1).
//   Matching frames are forwarded byte-exact; all others are silently dropped.
//   Saturating counters track accepted and dropped frames.
//
//   Optional feature macro: ETH_RX_FILTER_OVERSIZE_EN
//     When defined, a forwarded frame reaching MAX_FRAME_LEN bytes is cut
//     with m_axis_tlast and the remainder is discarded.
//
// Ports
//   gtx_tclk_i        clock
//   gtx_tresetn_i     asynchronous reset, active-high
//   s_axis_*          MAC RX stream in (tdata/tvalid/tlast/tready)
//   m_axis_*          registered stream out to decoder (tdata/tvalid/tlast/tready)
//   accept_bcast_i    also accept ff:ff:ff:ff:ff:ff
//   frames_accepted_o frames forwarded (saturating)
//   frames_dropped_o  frames dropped: mismatch, runt, oversize (saturating)
//   busy_o            high in any state other than IDLE
module eth_rx_mac_filter #(
  parameter logic [47:0] FPGA_MAC_ADDR = 48'h5a0102030405,
  parameter int unsigned MAX_FRAME_LEN = 1518,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             gtx_tclk_i,
  input  logic             gtx_tresetn_i,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  input  logic             accept_bcast_i,
  output logic [CNT_W-1:0] frames_accepted_o,
  output logic [CNT_W-1:0] frames_dropped_o,
  output logic             busy_o
);

`ifdef ETH_RX_FILTER_OVERSIZE_EN
  localparam bit OVERSIZE_EN = 1'b1;
`else
  localparam bit OVERSIZE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_RESYNC, S_IDLE, S_CAPTURE, S_FLUSH, S_PASS, S_DROP
  } state_t;

  state_t           r_state, w_next;
  logic [7:0]       r_hold [6];
  logic [2:0]       r_idx, w_idx_next;          // capture slot, then flush slot
  logic             r_flush_last, w_flush_last_next;
  logic [10:0]      r_bcnt;
  logic [7:0]       r_m_data;
  logic             r_m_valid, r_m_last;
  logic [CNT_W-1:0] r_acc, r_drop;

  logic        w_load, w_s_tready, w_beat, w_match, w_at_max;
  logic        w_out_en, w_out_last, w_inc_acc, w_inc_drop;
  logic [7:0]  w_out_data;
  logic [47:0] w_dest;

  assign w_load     = !r_m_valid | m_axis_tready;
  assign w_s_tready = (r_state == S_FLUSH) ? 1'b0 :
                      (r_state == S_PASS)  ? w_load : 1'b1;
  assign w_beat     = s_axis_tvalid & w_s_tready;

  // Compare uses the live 6th byte so the decision lands on the same beat.
  assign w_dest  = {r_hold[0], r_hold[1], r_hold[2], r_hold[3], r_hold[4], s_axis_tdata};
  assign w_match = (w_dest == FPGA_MAC_ADDR) | (accept_bcast_i & (w_dest == '1));
  assign w_at_max = OVERSIZE_EN && ((32'(r_bcnt) + 32'd1) == MAX_FRAME_LEN);

  always_comb begin
    w_next            = r_state;
    w_idx_next        = r_idx;
    w_flush_last_next = r_flush_last;
    w_out_en          = 1'b0;
    w_out_data        = s_axis_tdata;
    w_out_last        = 1'b0;
    w_inc_acc         = 1'b0;
    w_inc_drop        = 1'b0;
    case (r_state)
      S_RESYNC: if (w_beat && s_axis_tlast) w_next = S_IDLE;
      S_IDLE: begin
        if (w_beat) begin
          w_idx_next = 3'd1;
          if (s_axis_tlast) w_inc_drop = 1'b1;
          else              w_next     = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (w_beat) begin
          if (r_idx == 3'd5) begin
            if (w_match) begin
              w_next            = S_FLUSH;
              w_flush_last_next = s_axis_tlast;
              // hold[0] goes out on the deciding edge when the stage is free.
              if (w_load) begin
                w_out_en   = 1'b1;
                w_out_data = r_hold[0];
                w_idx_next = 3'd1;
              end else begin
                w_idx_next = 3'd0;
              end
            end else if (s_axis_tlast) begin
              w_inc_drop = 1'b1;
              w_next     = S_IDLE;
            end else begin
              w_next = S_DROP;
            end
          end else begin
            w_idx_next = r_idx + 3'd1;
            if (s_axis_tlast) begin
              w_inc_drop = 1'b1;
              w_next     = S_IDLE;
            end
          end
        end
      end
      S_FLUSH: begin
        if (w_load) begin
          w_out_en   = 1'b1;
          w_out_data = r_hold[r_idx];
          w_out_last = (r_idx == 3'd5) & r_flush_last;
          if (r_idx == 3'd5) begin
            w_idx_next = 3'd0;
            if (r_flush_last) begin
              w_inc_acc = 1'b1;
              w_next    = S_IDLE;
            end else begin
              w_next = S_PASS;
            end
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end
      S_PASS: begin
        if (w_beat) begin
          w_out_en   = 1'b1;
          w_out_last = s_axis_tlast | w_at_max;
          if (s_axis_tlast) begin
            w_inc_acc = 1'b1;
            w_next    = S_IDLE;
          end else if (w_at_max) begin
            w_inc_acc = 1'b1;
            w_next    = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (w_beat && s_axis_tlast) begin
          w_inc_drop = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_RESYNC;
    endcase
  end

  always_ff @(posedge gtx_tclk_i or posedge gtx_tresetn_i) begin
    if (gtx_tresetn_i) begin
      r_state      <= S_RESYNC;
      for (int unsigned i = 0; i < 6; i++) r_hold[i] <= '0;
      r_idx        <= '0;
      r_flush_last <= 1'b0;
      r_bcnt       <= '0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_acc        <= '0;
      r_drop       <= '0;
    end else begin
      r_state      <= w_next;
      r_idx        <= w_idx_next;
      r_flush_last <= w_flush_last_next;
      if (w_beat && r_state == S_IDLE)         r_hold[0]     <= s_axis_tdata;
      else if (w_beat && r_state == S_CAPTURE) r_hold[r_idx] <= s_axis_tdata;
      if (w_beat) begin
        if (s_axis_tlast)     r_bcnt <= '0;
        else if (r_bcnt != '1) r_bcnt <= r_bcnt + 11'd1;
      end
      if (w_out_en) begin
        r_m_data  <= w_out_data;
        r_m_valid <= 1'b1;
        r_m_last  <= w_out_last;
      end else if (m_axis_tready) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
      if (w_inc_acc  && r_acc  != '1) r_acc  <= r_acc  + 1'b1;
      if (w_inc_drop && r_drop != '1) r_drop <= r_drop + 1'b1;
    end
  end

  assign s_axis_tready     = w_s_tready;
  assign m_axis_tdata      = r_m_data;
  assign m_axis_tvalid     = r_m_valid;
  assign m_axis_tlast      = r_m_last;
  assign frames_accepted_o = r_acc;
  assign frames_dropped_o  = r_drop;
  assign busy_o            = (r_state != S_IDLE);

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// tb_eth_rx_mac_filter
//   Directed-frame bench: expected output beats are queued when a frame is
//   issued; a monitor pops and compares on every output handshake.
//   Counters are built with CNT_W=3 so saturation is reachable.
module tb_eth_rx_mac_filter;

  localparam int unsigned CW = 3;
`ifdef ETH_RX_FILTER_OVERSIZE_EN
  localparam int unsigned TB_MAX = 100;
`else
  localparam int unsigned TB_MAX = 1518;
`endif

  logic          clk, rst;
  logic [7:0]    s_data, m_data;
  logic          s_valid, s_last, s_ready;
  logic          m_valid, m_last, m_ready;
  logic          bcast, busy;
  logic [CW-1:0] acc, drop;

  eth_rx_mac_filter #(
    .FPGA_MAC_ADDR(48'h5a0102030405),
    .MAX_FRAME_LEN(TB_MAX),
    .CNT_W(CW)
  ) dut (
    .gtx_tclk_i(clk),
    .gtx_tresetn_i(rst),
    .s_axis_tdata(s_data),
    .s_axis_tvalid(s_valid),
    .s_axis_tlast(s_last),
    .s_axis_tready(s_ready),
    .m_axis_tdata(m_data),
    .m_axis_tvalid(m_valid),
    .m_axis_tlast(m_last),
    .m_axis_tready(m_ready),
    .accept_bcast_i(bcast),
    .frames_accepted_o(acc),
    .frames_dropped_o(drop),
    .busy_o(busy)
  );

  typedef struct packed {logic [7:0] d; logic l;} beat_t;
  beat_t exp_q[$];

  int   checks = 0;
  int   passes = 0;
  int   max_wait;
  int   exp_acc = 0;
  int   exp_drop = 0;
  bit   tog = 0;
  logic [7:0] fr [0:199];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output monitor: a handshake seen at negedge completes on the next posedge.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got data %0h last %0b expected no beat", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(m_data), 32'(e.d));
          check("out_last", 32'(m_last), 32'(e.l));
        end
      end
    end
  end

  // Downstream ready: constant 1, or toggling every cycle when tog=1.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = tog ? ~m_ready : 1'b1;
    end
  end

  function automatic int sat(input int v);
    return (v >= 7) ? 7 : v;
  endfunction

  task automatic build(input logic [47:0] dest, input int len);
    for (int i = 0; i < len; i++)
      fr[i] = (i < 6) ? dest[47-8*i -: 8] : 8'(i * 13 + 5);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    logic rdy;
    int   n;
    s_valid = 1'b1; s_data = d; s_last = l;
    n = 0;
    do begin
      @(negedge clk); rdy = s_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 1000);
    if (n > max_wait) max_wait = n;
    if (!rdy) begin
      checks++;
      $display("FAIL send_timeout: got no s_tready within %0d cycles expected acceptance", n);
    end
  endtask

  // Sends fr[0..len-1]; exp_n bytes are expected out, last flagged on the final one.
  task automatic send_frame(input int len, input int exp_n, input bit lat_chk);
    for (int i = 0; i < exp_n; i++) exp_q.push_back({fr[i], (i == exp_n - 1) ? 1'b1 : 1'b0});
    max_wait = 0;
    for (int i = 0; i < len; i++) begin
      send_byte(fr[i], (i == len - 1) ? 1'b1 : 1'b0);
      if (lat_chk && i == 5) check("first_valid_latency", 32'(m_valid), 32'd1);
    end
  endtask

  task automatic drain_and_check(input string tag);
    int n;
    s_valid = 1'b0; s_last = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL %s_drain: got %0d beats pending expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (4) begin @(posedge clk); #1; end
    check({tag, "_accepted"}, 32'(acc), 32'(exp_acc));
    check({tag, "_dropped"}, 32'(drop), 32'(exp_drop));
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; bcast = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_m_tvalid", 32'(m_valid), 32'd0);
    check("rst_m_tlast", 32'(m_last), 32'd0);
    check("rst_m_tdata", 32'(m_data), 32'd0);
    check("rst_s_tready", 32'(s_ready), 32'd1);
    check("rst_accepted", 32'(acc), 32'd0);
    check("rst_dropped", 32'(drop), 32'd0);

    // 1: reset released 40 bytes before the end of a matching frame
    build(48'h5a0102030405, 60);
    for (int i = 0; i < 20; i++) send_byte(fr[i], 1'b0);
    rst = 1'b0;
    for (int i = 20; i < 60; i++) send_byte(fr[i], (i == 59) ? 1'b1 : 1'b0);
    drain_and_check("resync");
    check("resync_idle_busy", 32'(busy), 32'd0);

    // 2: 64-byte matching frame, first output one cycle after byte 6
    build(48'h5a0102030405, 64);
    send_frame(64, 64, 1'b1);
    exp_acc = sat(exp_acc + 1);
    drain_and_check("match64");

    // 3: foreign destination, never stalled
    build(48'h985aebdb066f, 64);
    send_frame(64, 0, 1'b0);
    check("drop_tready_always", 32'(max_wait), 32'd1);
    exp_drop = sat(exp_drop + 1);
    drain_and_check("mismatch64");

    // 4: broadcast rejected, then accepted
    build(48'hffffffffffff, 64);
    send_frame(64, 0, 1'b0);
    exp_drop = sat(exp_drop + 1);
    drain_and_check("bcast_off");
    bcast = 1'b1;
    send_frame(64, 64, 1'b0);
    exp_acc = sat(exp_acc + 1);
    drain_and_check("bcast_on");
    bcast = 1'b0;

    // 5: 4-byte runt followed back-to-back by a matching frame
    build(48'h5a0102030405, 64);
    send_frame(4, 0, 1'b0);
    send_frame(64, 64, 1'b0);
    exp_drop = sat(exp_drop + 1);
    exp_acc  = sat(exp_acc + 1);
    drain_and_check("runt_b2b");

    // 6: downstream ready toggling every cycle
    tog = 1'b1;
    send_frame(64, 64, 1'b0);
    exp_acc = sat(exp_acc + 1);
    drain_and_check("toggle_ready");
    tog = 1'b0;

    // 6-byte frames: tlast on the deciding byte
    send_frame(6, 6, 1'b0);
    exp_acc = sat(exp_acc + 1);
    drain_and_check("match6");
    build(48'h5a0102030406, 6);
    send_frame(6, 0, 1'b0);
    exp_drop = sat(exp_drop + 1);
    drain_and_check("mismatch6");

`ifdef ETH_RX_FILTER_OVERSIZE_EN
    build(48'h5a0102030405, 150);
    send_frame(150, 100, 1'b0);
    exp_acc  = sat(exp_acc + 1);
    exp_drop = sat(exp_drop + 1);
    drain_and_check("oversize");
`endif

    // Saturation: push both counters beyond 7
    build(48'h5a0102030405, 8);
    for (int k = 0; k < 4; k++) begin
      send_frame(2, 0, 1'b0);
      exp_drop = sat(exp_drop + 1);
    end
    for (int k = 0; k < 3; k++) begin
      send_frame(8, 8, 1'b0);
      exp_acc = sat(exp_acc + 1);
    end
    drain_and_check("saturate");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
